nf_uart_rx_ovs: RTL

Parametrised UART receiver with 16x-style oversampling, majority-vote bit sampling and start-bit glitch rejection. Frame format is configurable at run time: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits. Received words are buffered in a small RX FIFO carrying per-word parity and framing error flags. It sits behind the UART bus-slave register block as the next generation of the existing fixed 8N1 receiver.

---
 rtl/nf_uart_pkg.sv | 32 +++
 rtl/nf_sync_fifo.sv | 81 ++++++++
 rtl/nf_uart_rx_ovs.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/nf_uart_pkg.sv
// nf_uart_pkg: shared types for the UART receive path.
//   rx_state_e  - receiver FSM states
//   PAR_*       - cfg_par encodings (3 behaves as none)
//   len_bits()  - cfg_len -> number of data bits (5..8)
//   rx_entry_t  - RX FIFO entry {ferr, perr, data}
package nf_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP2
  } rx_state_e;

  localparam logic [1:0] PAR_NONE  = 2'd0;
  localparam logic [1:0] PAR_EVEN  = 2'd1;
  localparam logic [1:0] PAR_ODD   = 2'd2;
  localparam logic [1:0] PAR_NONE3 = 2'd3;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic [3:0] len_bits(input logic [1:0] cfg_len);
    return 4'd5 + {2'b00, cfg_len};
  endfunction

endpackage

// File: rtl/nf_sync_fifo.sv
// nf_sync_fifo: single-clock FIFO with a registered head output.
//   clk, resetn  - clock, async active-high reset
//   wr_en/wr_data - push (dropped when full unless a pop happens the same cycle)
//   rd_en         - pop head (ignored when empty)
//   rd_data       - registered head entry, zero when empty
//   full, empty   - registered occupancy flags
module nf_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  // A pop frees the slot the same cycle, so push+pop while full both proceed.
  assign do_pop  = rd_en && (cnt_q != '0);
  assign do_push = wr_en && ((cnt_q != FULL_CNT) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Head looks through mem_d so a push into an empty FIFO shows next clk.
    head_d  = (cnt_d == '0) ? '0 : mem_d[rd_ptr_d];
    full_d  = (cnt_d == FULL_CNT);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rd_data = head_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/nf_uart_rx_ovs.sv
// nf_uart_rx_ovs: oversampling UART receiver with majority-vote sampling,
// start-bit glitch rejection, run-time frame format and an RX FIFO.
//   clk, resetn     - clock, async active-high reset
//   rec_en          - receiver enable; low parks FSM and counters
//   comp            - clk cycles per oversample tick (0 acts as 1)
//   cfg_len/par/stop2 - frame format, latched at start-bit detection
//   rx_rd, err_clr  - pop FIFO head, clear sticky overflow
//   rx_data/perr/ferr - registered FIFO head
//   rx_valid, rx_full, rx_ovf - FIFO status, sticky overflow
//   uart_rx         - serial line, idle high
module nf_uart_rx_ovs
  import nf_uart_pkg::*;
#(
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rec_en,
  input  logic [15:0] comp,
  input  logic [1:0]  cfg_len,
  input  logic [1:0]  cfg_par,
  input  logic        cfg_stop2,
  input  logic        rx_rd,
  input  logic        err_clr,
  output logic [7:0]  rx_data,
  output logic        rx_perr,
  output logic        rx_ferr,
  output logic        rx_valid,
  output logic        rx_full,
  output logic        rx_ovf,
  input  logic        uart_rx
);

  localparam int SW = $clog2(OVS);
  localparam logic [SW-1:0] SUB_M1  = SW'(OVS/2 - 1);
  localparam logic [SW-1:0] SUB_MID = SW'(OVS/2);
  localparam logic [SW-1:0] SUB_P1  = SW'(OVS/2 + 1);
  localparam logic [SW-1:0] SUB_END = SW'(OVS - 1);

  logic            sync1_q, sync1_d, sync2_q, sync2_d, rx_s;
  logic [15:0]     tick_cnt_q, tick_cnt_d, comp_m1;
  logic            tick;
  rx_state_e       state_q, state_d;
  logic [SW-1:0]   sub_q, sub_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            s0_q, s0_d, s1_q, s1_d, maj;
  logic            perr_q, perr_d, ferr_q, ferr_d;
  logic [3:0]      nbits_q, nbits_d;
  logic [1:0]      par_q, par_d;
  logic            stop2_q, stop2_d, par_en;
  logic            ovf_q, ovf_d, push;
  rx_entry_t       push_entry, head;
  logic [9:0]      head_raw;
  logic            fifo_full, fifo_empty;

  assign rx_s    = sync2_q;
  assign comp_m1 = (comp == 16'd0) ? 16'd0 : comp - 16'd1;
  assign tick    = rec_en && (tick_cnt_q >= comp_m1);
  assign maj     = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign par_en  = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

  always_comb begin
    sync1_d    = uart_rx;
    sync2_d    = sync1_q;
    tick_cnt_d = (!rec_en || tick) ? 16'd0 : tick_cnt_q + 16'd1;
    // A new overflow outranks a simultaneous clear.
    ovf_d      = (push && fifo_full && !rx_rd) ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
  end

  // Bit timing: the detecting tick in IDLE counts as sub 0. The vote is
  // resolved on the third sample (OVS/2+1); a bit always spans OVS ticks.
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    bit_d   = bit_q;
    data_d  = data_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    nbits_d = nbits_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    push    = 1'b0;
    if (!rec_en) begin
      state_d = IDLE;
      sub_d   = '0;
      bit_d   = '0;
    end else if (tick) begin
      if (state_q != IDLE) begin
        if (sub_q == SUB_M1)  s0_d = rx_s;
        if (sub_q == SUB_MID) s1_d = rx_s;
        sub_d = (sub_q == SUB_END) ? '0 : sub_q + 1'b1;
      end
      case (state_q)
        IDLE: if (!rx_s) begin
          state_d = START;
          sub_d   = SW'(1);
          bit_d   = '0;
          data_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          nbits_d = len_bits(cfg_len);
          par_d   = cfg_par;
          stop2_d = cfg_stop2;
        end
        START: begin
          if (sub_q == SUB_P1 && maj) begin
            state_d = IDLE;
            sub_d   = '0;
          end else if (sub_q == SUB_END) begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (sub_q == SUB_P1) data_d[bit_q] = maj;
          if (sub_q == SUB_END) begin
            if ({1'b0, bit_q} == nbits_q - 4'd1) state_d = par_en ? PARITY : STOP;
            else                                  bit_d   = bit_q + 1'b1;
          end
        end
        PARITY: begin
          if (sub_q == SUB_P1)  perr_d  = (^data_q) ^ maj ^ (par_q == PAR_ODD);
          if (sub_q == SUB_END) state_d = STOP;
        end
        STOP: begin
          if (sub_q == SUB_P1) begin
            ferr_d = !maj;
            if (!stop2_q) begin
              push    = 1'b1;
              state_d = IDLE;
              sub_d   = '0;
            end
          end else if (sub_q == SUB_END) begin
            state_d = STOP2;
          end
        end
        STOP2: if (sub_q == SUB_P1) begin
          ferr_d  = ferr_q | !maj;
          push    = 1'b1;
          state_d = IDLE;
          sub_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
    push_entry = '{ferr: ferr_d, perr: perr_q, data: data_q};
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      tick_cnt_q <= '0;
      state_q    <= IDLE;
      sub_q      <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      nbits_q    <= 4'd8;
      par_q      <= PAR_NONE;
      stop2_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      sub_q      <= sub_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      nbits_q    <= nbits_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      ovf_q      <= ovf_d;
    end
  end

  nf_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(rx_entry_t))
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (push),
    .wr_data (push_entry),
    .rd_en   (rx_rd),
    .rd_data (head_raw),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head     = head_raw;
  assign rx_data  = head.data;
  assign rx_perr  = head.perr;
  assign rx_ferr  = head.ferr;
  assign rx_valid = !fifo_empty;
  assign rx_full  = fifo_full;
  assign rx_ovf   = ovf_q;

endmodule
